booth_mul_seq: RTL

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_step.sv | 41 ++++
 rtl/booth_mul_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding, the default operand width and the step-counter width.
package booth_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: add/subtract the multiplicand into U, then shift {U,V,X} right arithmetically.
// Purely combinational (zero latency); there is no handshake, so it never stalls.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0]   u_i,
   input  logic [WIDTH-1:0] v_i,
   input  logic             x_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH:0]   u_o,
   output logic [WIDTH-1:0] v_o,
   output logic             x_o
);

   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] addend;
   logic [WIDTH:0] cin;
   logic [WIDTH:0] sum;

   always_comb begin
      m_ext  = {m_i[WIDTH-1], m_i};
      addend = '0;
      cin    = '0;
      // Subtraction is done as U + ~M + 1 so a single adder covers both cases.
      case ({v_i[0], x_i})
         2'b10: begin
            addend = ~m_ext;
            cin    = {{WIDTH{1'b0}}, 1'b1};
         end
         2'b01: addend = m_ext;
         default: addend = '0;
      endcase
      sum = u_i + addend + cin;
      u_o = {sum[WIDTH], sum[WIDTH:1]};
      v_o = {sum[0], v_i[WIDTH-1:1]};
      x_o = v_i[0];
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed multiplier: one Booth step per clock, product after WIDTH cycles.
// op_start is only honoured in IDLE; a finished result holds until op_clear or reset.
module booth_mul_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 op_start,
   input  logic                 op_clear,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplicand,
   output logic                 op_done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH:0]   u_q, u_d;
   logic [WIDTH-1:0] v_q, v_d;
   logic             x_q, x_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH:0]   step_u;
   logic [WIDTH-1:0] step_v;
   logic             step_x;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .u_i (u_q),
      .v_i (v_q),
      .x_i (x_q),
      .m_i (m_q),
      .u_o (step_u),
      .v_o (step_v),
      .x_o (step_x)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         u_q     <= '0;
         v_q     <= '0;
         x_q     <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         v_q     <= v_d;
         x_q     <= x_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      u_d     = u_q;
      v_d     = v_q;
      x_d     = x_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      if (op_clear) begin
         state_d = ST_IDLE;
         u_d     = '0;
         v_d     = '0;
         x_d     = 1'b0;
         m_d     = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (op_start) begin
                  state_d = ST_EXEC;
                  u_d     = '0;
                  v_d     = multiplier;
                  x_d     = 1'b0;
                  m_d     = multiplicand;
                  cnt_d   = '0;
               end
            end
            ST_EXEC: begin
               u_d   = step_u;
               v_d   = step_v;
               x_d   = step_x;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end

      // The product is gated so nothing partial leaks out before completion.
      op_done = (state_q == ST_DONE);
      result  = op_done ? {u_q[WIDTH-1:0], v_q} : '0;
   end

endmodule
